// File: rtl/jt5205_mc_if.sv
// Nibble push handshake between the sound-ROM fetch side and the multi-channel ADPCM decoder.
// Channel k owns din[4k+3:4k], din_valid[k] and din_ready[k].
interface jt5205_mc_if #(
  parameter int unsigned CH = 2
);
  logic [4*CH-1:0] din;
  logic [CH-1:0]   din_valid;
  logic [CH-1:0]   din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/jt5205_mc.sv
// Multi-channel MSM5205-style ADPCM decoder: per-channel rate dividers and nibble FIFOs
// feeding one time-shared two-stage decode pipe, with per-channel outputs and a summed mix.
module jt5205_mc #(
  parameter int unsigned CH = 2,
  parameter int unsigned FD = 4,
  parameter int unsigned MW = 12 + $clog2(CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic [2*CH-1:0]      sel,
  jt5205_mc_if.slave           bus,
  output logic [12*CH-1:0]     sound,
  output logic signed [MW-1:0] mix,
  output logic [CH-1:0]        sample,
  output logic [CH-1:0]        underrun
);
  localparam int unsigned AW = $clog2(FD);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = (CH > 1) ? $clog2(CH) : 1;

  // Dialogic step table
  function automatic logic [10:0] step_lut(input logic [5:0] idx);
    step_lut = 11'd1552;
    case (idx)
      6'd0 : step_lut = 11'd16;   6'd1 : step_lut = 11'd17;   6'd2 : step_lut = 11'd19;
      6'd3 : step_lut = 11'd21;   6'd4 : step_lut = 11'd23;   6'd5 : step_lut = 11'd25;
      6'd6 : step_lut = 11'd28;   6'd7 : step_lut = 11'd31;   6'd8 : step_lut = 11'd34;
      6'd9 : step_lut = 11'd37;   6'd10: step_lut = 11'd41;   6'd11: step_lut = 11'd45;
      6'd12: step_lut = 11'd50;   6'd13: step_lut = 11'd55;   6'd14: step_lut = 11'd60;
      6'd15: step_lut = 11'd66;   6'd16: step_lut = 11'd73;   6'd17: step_lut = 11'd80;
      6'd18: step_lut = 11'd88;   6'd19: step_lut = 11'd97;   6'd20: step_lut = 11'd107;
      6'd21: step_lut = 11'd118;  6'd22: step_lut = 11'd130;  6'd23: step_lut = 11'd143;
      6'd24: step_lut = 11'd157;  6'd25: step_lut = 11'd173;  6'd26: step_lut = 11'd190;
      6'd27: step_lut = 11'd209;  6'd28: step_lut = 11'd230;  6'd29: step_lut = 11'd253;
      6'd30: step_lut = 11'd279;  6'd31: step_lut = 11'd307;  6'd32: step_lut = 11'd337;
      6'd33: step_lut = 11'd371;  6'd34: step_lut = 11'd408;  6'd35: step_lut = 11'd449;
      6'd36: step_lut = 11'd494;  6'd37: step_lut = 11'd544;  6'd38: step_lut = 11'd598;
      6'd39: step_lut = 11'd658;  6'd40: step_lut = 11'd724;  6'd41: step_lut = 11'd796;
      6'd42: step_lut = 11'd876;  6'd43: step_lut = 11'd963;  6'd44: step_lut = 11'd1060;
      6'd45: step_lut = 11'd1166; 6'd46: step_lut = 11'd1282; 6'd47: step_lut = 11'd1411;
      default: step_lut = 11'd1552;
    endcase
  endfunction

  function automatic logic [6:0] div_last(input logic [1:0] s);
    case (s)
      2'b00:   div_last = 7'd95;
      2'b01:   div_last = 7'd63;
      default: div_last = 7'd47;
    endcase
  endfunction

  logic [1:0]        r_sel_q [CH];
  logic [6:0]        r_div   [CH];
  logic [CH-1:0]     r_pend;
  logic [3:0]        r_mem   [CH][FD];
  logic [AW-1:0]     r_wp    [CH];
  logic [AW-1:0]     r_rp    [CH];
  logic [CW-1:0]     r_cnt   [CH];
  logic [CH-1:0]     r_ready;
  logic [SW-1:0]     r_slot;
  logic signed [11:0] r_sig  [CH];
  logic [5:0]        r_idx   [CH];

  logic              r_s1_vld;
  logic [SW-1:0]     r_s1_ch;
  logic [3:0]        r_s1_nib;
  logic signed [11:0] r_s1_sig;
  logic [5:0]        r_s1_idx;
  logic [11:0]       r_s1_delta;

  logic [CH-1:0]     r_sample;
  logic [CH-1:0]     r_underrun;
  logic signed [MW-1:0] r_mix;

  logic              w_issue, w_empty, w_pop, w_under;
  logic [3:0]        w_nib;
  logic [10:0]       w_step;
  logic [11:0]       w_delta;
  logic [CH-1:0]     w_push, w_pop_ch, w_onehot;
  logic [CW-1:0]     w_cnt_nxt [CH];
  logic signed [13:0] w_acc;
  logic signed [11:0] w_sig_new;
  logic signed [7:0] w_adj, w_isum;
  logic [5:0]        w_idx_new;
  logic signed [MW-1:0] w_mix;

  // Scheduler issue decision and stage-1 delta for the channel owning this slot
  always_comb begin
    w_issue  = r_pend[r_slot] && !(r_s1_vld && (r_s1_ch == r_slot));
    w_empty  = (r_cnt[r_slot] == '0);
    w_pop    = w_issue && !w_empty;
    w_under  = w_issue && w_empty;
    w_onehot = CH'(1) << r_slot;
    w_nib    = r_mem[r_slot][r_rp[r_slot]];
    w_step   = step_lut(r_idx[r_slot]);
    w_delta  = 12'(w_step >> 3)
             + (w_nib[2] ? 12'(w_step)      : 12'd0)
             + (w_nib[1] ? 12'(w_step >> 1) : 12'd0)
             + (w_nib[0] ? 12'(w_step >> 2) : 12'd0);
  end

  // FIFO occupancy bookkeeping
  always_comb begin
    w_push   = bus.din_valid & r_ready;
    w_pop_ch = '0;
    for (int k = 0; k < CH; k++) begin
      w_pop_ch[k]  = w_pop && (r_slot == SW'(k));
      w_cnt_nxt[k] = r_cnt[k] + CW'(w_push[k]) - CW'(w_pop_ch[k]);
    end
  end

  // Stage 2: add/clamp signal and index
  always_comb begin
    w_acc = r_s1_nib[3] ? (14'(r_s1_sig) - $signed({2'b00, r_s1_delta}))
                        : (14'(r_s1_sig) + $signed({2'b00, r_s1_delta}));
    if (w_acc > 14'sd2047)       w_sig_new = 12'sd2047;
    else if (w_acc < -14'sd2048) w_sig_new = 12'sh800;
    else                         w_sig_new = w_acc[11:0];
    case (r_s1_nib[2:0])
      3'd4:    w_adj = 8'sd2;
      3'd5:    w_adj = 8'sd4;
      3'd6:    w_adj = 8'sd6;
      3'd7:    w_adj = 8'sd8;
      default: w_adj = -8'sd1;
    endcase
    w_isum = $signed({2'b00, r_s1_idx}) + w_adj;
    if (w_isum < 8'sd0)       w_idx_new = 6'd0;
    else if (w_isum > 8'sd48) w_idx_new = 6'd48;
    else                      w_idx_new = w_isum[5:0];
  end

  always_comb begin
    w_mix = '0;
    for (int k = 0; k < CH; k++) w_mix = w_mix + MW'(r_sig[k]);
  end

  // Rate dividers and pending flags; a tick outranks a same-cycle issue clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      for (int k = 0; k < CH; k++) begin
        r_div[k]   <= '0;
        r_sel_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        r_sel_q[k] <= sel[2*k +: 2];
        if (w_issue && (r_slot == SW'(k))) r_pend[k] <= 1'b0;
        if (sel[2*k +: 2] == 2'b11) begin
          r_div[k]  <= '0;
          r_pend[k] <= 1'b0;
        end else if (sel[2*k +: 2] != r_sel_q[k]) begin
          r_div[k] <= '0;
        end else if (cen) begin
          if (r_div[k] == div_last(sel[2*k +: 2])) begin
            r_div[k]  <= '0;
            r_pend[k] <= 1'b1;
          end else begin
            r_div[k] <= r_div[k] + 7'd1;
          end
        end
      end
    end
  end

  // Per-channel nibble FIFOs; ready reflects next-cycle fullness only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= '0;
      for (int k = 0; k < CH; k++) begin
        r_wp[k]  <= '0;
        r_rp[k]  <= '0;
        r_cnt[k] <= '0;
        for (int j = 0; j < FD; j++) r_mem[k][j] <= '0;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        r_cnt[k]   <= w_cnt_nxt[k];
        r_ready[k] <= (w_cnt_nxt[k] != CW'(FD));
        if (w_push[k]) begin
          r_mem[k][r_wp[k]] <= bus.din[4*k +: 4];
          r_wp[k]           <= r_wp[k] + 1'b1;
        end
        if (w_pop_ch[k]) r_rp[k] <= r_rp[k] + 1'b1;
      end
    end
  end

  // Slot counter, decode pipe, write-back and output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot     <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_nib   <= '0;
      r_s1_sig   <= '0;
      r_s1_idx   <= '0;
      r_s1_delta <= '0;
      r_sample   <= '0;
      r_underrun <= '0;
      r_mix      <= '0;
      for (int k = 0; k < CH; k++) begin
        r_sig[k] <= '0;
        r_idx[k] <= '0;
      end
    end else begin
      r_slot     <= (r_slot == SW'(CH - 1)) ? '0 : r_slot + 1'b1;
      r_s1_vld   <= w_pop;
      r_s1_ch    <= r_slot;
      r_s1_nib   <= w_nib;
      r_s1_sig   <= r_sig[r_slot];
      r_s1_idx   <= r_idx[r_slot];
      r_s1_delta <= w_delta;
      r_underrun <= w_under ? w_onehot : '0;
      r_sample   <= '0;
      r_mix      <= w_mix;
      if (r_s1_vld) begin
        r_sig[r_s1_ch] <= w_sig_new;
        r_idx[r_s1_ch] <= w_idx_new;
        r_sample       <= CH'(1) << r_s1_ch;
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_sound
    assign sound[12*k +: 12] = r_sig[k];
  end

  assign bus.din_ready = r_ready;
  assign mix           = r_mix;
  assign sample        = r_sample;
  assign underrun      = r_underrun;

endmodule

// File: doc/jt5205_mc.md
# jt5205_mc

Multi-channel successor to the single-voice MSM5205-compatible ADPCM decoder. It decodes CH independent 4-bit ADPCM streams, each at its own rate, through one time-shared decode datapath. Each channel has its own nibble FIFO with a valid/ready handshake, and the block produces per-channel 12-bit outputs plus a full-precision mix. It sits between the CPU/sound-ROM fetch logic and the game's audio mixer.

## Interface
Parameters:
- CH, 2, number of channels (1..8)
- FD, 4, per-channel FIFO depth in nibbles (power of two, ≥2)
- MW, 12+$clog2(CH), mix output width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cen  in  1  clock enable equivalent to the 384 kHz MSM5205 oscillator
- sel  in  2*CH  per-channel rate select (S pins), channel k at [2k+1:2k]
- din  in  4*CH  per-channel ADPCM nibble, channel k at [4k+3:4k]
- din_valid  in  CH  nibble offered on channel k
- din_ready  out  CH  channel k FIFO not full
- sound  out  12*CH  signed decoded sample per channel
- mix  out  MW  signed sum of all channel outputs
- sample  out  CH  one-clk pulse when channel k's sound updates
- underrun  out  CH  one-clk pulse when channel k's sample tick finds its FIFO empty

## Operation
- Rate divider per channel counts cen pulses:
  - sel 00 → /96 (4 kHz); 01 → /64 (6 kHz); 10 → /48 (8 kHz)
  - 11 → stopped: divider held at 0, pending cleared
  - The divider restarts at 0 whenever sel changes.
  - On terminal count it sets the channel's pending flag.
- FIFO: push when din_valid && din_ready. din_ready is low when full, regardless of a same-cycle pop. Pop only by the decoder.
- Scheduler: a slot counter cycles 0..CH-1 every clk, independent of cen. In slot k, the channel is issued if pending[k] is set:
  - FIFO non-empty: pop one nibble, clear pending[k], enter the decode pipe.
  - FIFO empty: clear pending[k], pulse underrun[k]. sound[k] and the decoder state are held; no decode.
- Decoder state per channel: signal (12-bit signed) and index (0..48). Step table is the standard Dialogic 49 entries (index 0 = 16, index 48 = 1552).
- Decode, nibble b3..b0, step = table[index]:
  - delta = (step>>3) + (b2?step:0) + (b1?step>>1:0) + (b0?step>>2:0)
  - signal ← clamp(signal ± delta, −2048, 2047), where b3=1 subtracts.
  - index ← clamp(index + adj[b2:b0], 0, 48), adj = {−1,−1,−1,−1,2,4,6,8}.
- sound[k] = signal of channel k. mix = sign-extended sum of all sound[k]; no saturation needed at MW.
- sel=11 leaves FIFO contents and decoder state untouched.

## Timing
- Reset, asynchronous: all outputs are 0, including din_ready. The following are also cleared: FIFOs, pending, dividers, signal, index, slot counter.
- din_ready rises on the first clk after rst_n deasserts.
- Decode pipe has two stages:
  - Stage 1 (issue clk): read state and step, compute delta.
  - Stage 2: add/clamp, write back state, update sound[k], pulse sample[k].
- sample[k] is high on the clk in which sound[k] takes its new value. mix updates one clk later.
- Pending-to-issue latency ≤ CH clk. Pending always clears before the next tick, since the tick period is ≥48 cen.
- Back-to-back issues to different channels on consecutive clk are legal. The same channel cannot reissue before its write-back completes.
- Push and pop on the same clk with FIFO neither empty nor full: occupancy is unchanged.
- FIFO read/write pointers wrap modulo FD.
- A push to an empty FIFO is visible to the scheduler on the next clk.

## Test plan
- Reset: hold rst_n low mid-stream → all outputs 0 immediately, no clk edge needed; after release, din_ready = all ones and sound = 0.
- Decode, ch0, sel=10: push 0x7 then 0xF → sound[0] = 30 (index 8), then −33 (index 16); sample[0] pulses twice, 48 cen apart.
- Saturation: push 0x7 repeatedly on ch0 → sound[0] reaches 2047 and stays; index clamps at 48. Repeat with 0xF → −2048.
- Rates: ch0 sel=00, ch1 sel=10, FIFOs kept fed, 9600 cen → exactly 100 sample[0] and 200 sample[1] pulses, with no underrun.
- Underrun/FIFO: ch0 sel=11, push 5 nibbles → only 4 accepted, din_ready[0] low after the 4th. Set sel=10 → 4 decodes, then underrun[0] pulses at the 5th tick while sound[0] holds.
- Mix: ch0 = 30, ch1 = −33 → mix = −3, one clk after the later sample pulse.
